edc_mem_scrubber: RTL and testbench

Background ECC scrubber for the EDC-protected main memory. It walks every word address in turn and reads data plus stored ECC. An internal edc_generator (check mode) and edc_corrector correct single-bit errors, and the corrected word is written back with freshly generated ECC; uncorrectable words are only reported. It sits alongside the Wishbone memory path as a second, lower-priority requester on the memory arbiter.

---
 rtl/edc_mem_scrubber.sv | 258 +++++++++++++++++++++++++
 tb/tb_edc_mem_scrubber.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edc_mem_scrubber.sv
// Background SECDED scrubber: walks every word address, rewrites single-bit
// errors with fresh ECC and reports uncorrectable words.
module edc_mem_scrubber #(
  parameter int          ADDR_W   = 10,
  parameter int          INTERVAL = 1024,
  parameter logic [15:0] CNT_SAT  = 16'hFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_clear_counts,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [7:0]        o_mem_wecc,
  input  logic              i_mem_gnt,
  input  logic [31:0]       i_mem_rdata,
  input  logic [7:0]        i_mem_recc,
  input  logic              i_bus_wr,
  input  logic [ADDR_W-1:0] i_bus_addr,
  output logic              o_err_valid,
  output logic [ADDR_W-1:0] o_err_addr,
  output logic              o_err_uncorr,
  output logic [15:0]       o_corr_cnt,
  output logic [15:0]       o_uncorr_cnt,
  output logic              o_pass_done
);

  // state     | meaning
  // S_IDLE    | interval timer running
  // S_RD_REQ  | read request pending
  // S_RD_WAIT | read data arriving, decode and report
  // S_CHECK   | decide write-back or advance
  // S_WR_REQ  | write-back request pending
  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_CHECK, S_WR_REQ} state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        corr;
    logic        uncorr;
  } dec_t;

  localparam int TMR_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(INTERVAL - 1);

  // Hamming positions 1..38 with checks at powers of two, ecc[6] is overall
  // parity, ecc[7] is always written 0 so a flip there is a single error.
  function automatic logic [7:0] edc_gen(input logic [31:0] d);
    logic [7:0] e;
    logic [5:0] di;
    e  = '0;
    di = '0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int k = 0; k < 6; k++)
          if (p[k]) e[k] = e[k] ^ d[di[4:0]];
        di = di + 6'd1;
      end
    end
    e[6] = ^{d, e[5:0]};
    return e;
  endfunction

  function automatic dec_t edc_correct(input logic [31:0] d, input logic [7:0] e);
    dec_t       r;
    logic [7:0] g;
    logic [5:0] syn;
    logic       par;
    logic [5:0] di;
    g        = edc_gen(d);
    syn      = g[5:0] ^ e[5:0];
    par      = ^{d, e[6:0]};
    r.data   = d;
    r.corr   = 1'b0;
    r.uncorr = 1'b0;
    di       = '0;
    if (e[7]) begin
      if (syn == 6'd0 && !par) r.corr = 1'b1;
      else                     r.uncorr = 1'b1;
    end else if (par) begin
      if (syn > 6'd38) begin
        r.uncorr = 1'b1;
      end else begin
        r.corr = 1'b1;
        for (int p = 3; p < 39; p++) begin
          if ((p & (p - 1)) != 0) begin
            if (syn == 6'(p)) r.data[di[4:0]] = ~r.data[di[4:0]];
            di = di + 6'd1;
          end
        end
      end
    end else if (syn != 6'd0) begin
      r.uncorr = 1'b1;
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                abort_q, abort_d;
  logic                corr_q, corr_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [7:0]          wecc_q, wecc_d;
  logic                err_valid_q, err_valid_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                err_uncorr_q, err_uncorr_d;
  logic [15:0]         corr_cnt_q, corr_cnt_d;
  logic [15:0]         uncorr_cnt_q, uncorr_cnt_d;
  logic                pass_done_q, pass_done_d;
  logic                hit, adv, corr_inc, uncorr_inc;
  dec_t                dec;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    ptr_d        = ptr_q;
    abort_d      = abort_q;
    corr_d       = corr_q;
    req_d        = req_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wecc_d       = wecc_q;
    err_valid_d  = 1'b0;
    err_addr_d   = err_addr_q;
    err_uncorr_d = err_uncorr_q;
    pass_done_d  = 1'b0;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    adv          = 1'b0;
    corr_inc     = 1'b0;
    uncorr_inc   = 1'b0;
    dec          = edc_correct(i_mem_rdata, i_mem_recc);
    hit          = i_bus_wr && (i_bus_addr == ptr_q);

    case (state_q)
      S_IDLE: begin
        if (!i_enable) begin
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          timer_d = '0;
          abort_d = 1'b0;
          req_d   = 1'b1;
          we_d    = 1'b0;
          state_d = S_RD_REQ;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RD_REQ: begin
        if (i_mem_gnt) begin
          req_d   = 1'b0;
          abort_d = hit;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        corr_d  = dec.corr;
        wdata_d = dec.data;
        wecc_d  = edc_gen(dec.data);
        abort_d = abort_q | hit;
        if (dec.corr || dec.uncorr) begin
          err_valid_d  = 1'b1;
          err_addr_d   = ptr_q;
          err_uncorr_d = dec.uncorr;
        end
        corr_inc   = dec.corr;
        uncorr_inc = dec.uncorr;
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        if (corr_q && !(abort_q || hit)) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          state_d = S_WR_REQ;
        end else begin
          adv     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_REQ: begin
        // A grant already accepted wins over a same-cycle bus collision.
        if (i_mem_gnt || abort_q || hit) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          adv     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      ptr_d       = ptr_q + 1'b1;
      pass_done_d = &ptr_q;
    end

    if (i_clear_counts) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else begin
      if (corr_inc && corr_cnt_q != CNT_SAT)     corr_cnt_d   = corr_cnt_q + 16'd1;
      if (uncorr_inc && uncorr_cnt_q != CNT_SAT) uncorr_cnt_d = uncorr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      ptr_q        <= '0;
      abort_q      <= 1'b0;
      corr_q       <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wecc_q       <= '0;
      err_valid_q  <= 1'b0;
      err_addr_q   <= '0;
      err_uncorr_q <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      pass_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ptr_q        <= ptr_d;
      abort_q      <= abort_d;
      corr_q       <= corr_d;
      req_q        <= req_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wecc_q       <= wecc_d;
      err_valid_q  <= err_valid_d;
      err_addr_q   <= err_addr_d;
      err_uncorr_q <= err_uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      pass_done_q  <= pass_done_d;
    end
  end

  assign o_mem_req    = req_q;
  assign o_mem_we     = we_q;
  assign o_mem_addr   = ptr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_wecc   = wecc_q;
  assign o_err_valid  = err_valid_q;
  assign o_err_addr   = err_addr_q;
  assign o_err_uncorr = err_uncorr_q;
  assign o_corr_cnt   = corr_cnt_q;
  assign o_uncorr_cnt = uncorr_cnt_q;
  assign o_pass_done  = pass_done_q;

endmodule

// File: tb/tb_edc_mem_scrubber.sv
// Bench for edc_mem_scrubber: memory model, search-based ECC reference decoder,
// directed scenarios followed by randomized scrub steps.
module tb_edc_mem_scrubber;
  localparam int          AW  = 2;
  localparam int          IV  = 4;
  localparam int          NW  = 1 << AW;
  localparam logic [15:0] SAT = 16'd20;

  logic          i_clk, i_rst_n, i_enable, i_clear_counts;
  logic          o_mem_req, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [7:0]    o_mem_wecc;
  logic          i_mem_gnt;
  logic [31:0]   i_mem_rdata;
  logic [7:0]    i_mem_recc;
  logic          i_bus_wr;
  logic [AW-1:0] i_bus_addr;
  logic          o_err_valid;
  logic [AW-1:0] o_err_addr;
  logic          o_err_uncorr;
  logic [15:0]   o_corr_cnt, o_uncorr_cnt;
  logic          o_pass_done;

  edc_mem_scrubber #(.ADDR_W(AW), .INTERVAL(IV), .CNT_SAT(SAT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_clear_counts(i_clear_counts),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wecc(o_mem_wecc), .i_mem_gnt(i_mem_gnt),
    .i_mem_rdata(i_mem_rdata), .i_mem_recc(i_mem_recc), .i_bus_wr(i_bus_wr),
    .i_bus_addr(i_bus_addr), .o_err_valid(o_err_valid), .o_err_addr(o_err_addr),
    .o_err_uncorr(o_err_uncorr), .o_corr_cnt(o_corr_cnt), .o_uncorr_cnt(o_uncorr_cnt),
    .o_pass_done(o_pass_done));

  int n_tot = 0, n_bad = 0, cyc = 0, pass_seen = 0;
  int exp_ptr = 0, exp_corr = 0, exp_uncorr = 0, exp_wraps = 0;
  logic [31:0] mem_d [NW];
  logic [7:0]  mem_e [NW];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;
  always @(negedge i_clk) if (o_pass_done === 1'b1) pass_seen++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Codeword laid out by position: data fills the non-power-of-two slots 1..38.
  function automatic logic [7:0] ref_gen(input logic [31:0] d);
    logic [38:0] cw;
    logic [7:0]  e;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p < 39; p++)
      if ($countones(p) != 1) begin cw[p] = d[j]; j++; end
    e = '0;
    for (int k = 0; k < 6; k++)
      for (int p = 1; p < 39; p++)
        if ((p & (1 << k)) != 0) e[k] = e[k] ^ cw[p];
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  // 0 clean, 1 one flip away from a valid codeword, 2 anything else.
  function automatic int ref_classify(input logic [31:0] d, input logic [7:0] e,
                                      output logic [31:0] fixed);
    fixed = d;
    if (ref_gen(d) == e) return 0;
    for (int i = 0; i < 32; i++)
      if (ref_gen(d ^ (32'd1 << i)) == e) begin fixed = d ^ (32'd1 << i); return 1; end
    for (int j = 0; j < 8; j++)
      if (ref_gen(d) == (e ^ (8'd1 << j))) return 1;
    return 2;
  endfunction

  task automatic set_word(input int a, input logic [31:0] d, input int nflip);
    logic [39:0] cw;
    int b1, b2;
    cw = {ref_gen(d), d};
    b1 = $urandom_range(0, 39);
    b2 = (b1 + 1 + $urandom_range(0, 38)) % 40;
    if (nflip >= 1) cw[b1] = ~cw[b1];
    if (nflip >= 2) cw[b2] = ~cw[b2];
    mem_d[a] = cw[31:0];
    mem_e[a] = cw[39:32];
  endtask

  task automatic wait_req();
    int n = 0;
    while (o_mem_req !== 1'b1 && n < 200) begin @(negedge i_clk); n++; end
    chk("rd_req_seen", o_mem_req, 1'b1);
  endtask

  task automatic do_step(input bit collide, input int rdly, input int wdly,
                         input bit clr, output int t_req);
    logic [31:0] fixed;
    int cls, a;
    a = exp_ptr;
    wait_req();
    t_req = cyc;
    chk("rd_we", o_mem_we, 1'b0);
    chk("rd_addr", o_mem_addr, a);
    repeat (rdly) begin
      @(negedge i_clk);
      chk("rd_hold_req", o_mem_req, 1'b1);
      chk("rd_hold_addr", o_mem_addr, a);
    end
    i_mem_gnt = 1'b1;
    @(negedge i_clk);
    i_mem_gnt   = 1'b0;
    i_mem_rdata = mem_d[a];
    i_mem_recc  = mem_e[a];
    cls = ref_classify(mem_d[a], mem_e[a], fixed);
    if (collide) begin
      i_bus_wr   = 1'b1;
      i_bus_addr = AW'(a);
      mem_d[a]   = $urandom;
      mem_e[a]   = ref_gen(mem_d[a]);
    end
    if (clr) i_clear_counts = 1'b1;
    @(negedge i_clk);
    i_bus_wr = 1'b0;
    i_clear_counts = 1'b0;
    i_mem_rdata = $urandom;
    i_mem_recc  = 8'($urandom);
    if (clr) begin exp_corr = 0; exp_uncorr = 0; end
    else if (cls == 1 && exp_corr < int'(SAT)) exp_corr++;
    else if (cls == 2 && exp_uncorr < int'(SAT)) exp_uncorr++;
    chk("err_valid", o_err_valid, cls != 0);
    if (cls != 0) begin
      chk("err_addr", o_err_addr, a);
      chk("err_uncorr", o_err_uncorr, cls == 2);
    end
    chk("corr_cnt", o_corr_cnt, exp_corr);
    chk("uncorr_cnt", o_uncorr_cnt, exp_uncorr);
    @(negedge i_clk);
    if (cls == 1 && !collide) begin
      for (int k = 0; k <= wdly; k++) begin
        if (k > 0) @(negedge i_clk);
        chk("wr_req", o_mem_req, 1'b1);
        chk("wr_we", o_mem_we, 1'b1);
        chk("wr_addr", o_mem_addr, a);
        chk("wr_data", o_mem_wdata, fixed);
        chk("wr_ecc", o_mem_wecc, ref_gen(fixed));
      end
      i_mem_gnt = 1'b1;
      @(negedge i_clk);
      i_mem_gnt = 1'b0;
      mem_d[a] = fixed;
      mem_e[a] = ref_gen(fixed);
      chk("wr_released", o_mem_req, 1'b0);
    end else begin
      chk("no_wr", o_mem_req, 1'b0);
    end
    exp_ptr = (a + 1) % NW;
    if (a == NW - 1) exp_wraps++;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, seen;
    i_rst_n = 1'b0; i_enable = 1'b1; i_clear_counts = 1'b0; i_mem_gnt = 1'b0;
    i_mem_rdata = '0; i_mem_recc = '0; i_bus_wr = 1'b0; i_bus_addr = '0;
    for (int i = 0; i < NW; i++) set_word(i, $urandom, 0);
    repeat (3) @(negedge i_clk);
    chk("rst_req", o_mem_req, 1'b0);
    chk("rst_we", o_mem_we, 1'b0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_wecc", o_mem_wecc, 0);
    chk("rst_err_valid", o_err_valid, 1'b0);
    chk("rst_err_addr", o_err_addr, 0);
    chk("rst_corr_cnt", o_corr_cnt, 0);
    chk("rst_uncorr_cnt", o_uncorr_cnt, 0);
    chk("rst_pass_done", o_pass_done, 1'b0);
    i_rst_n = 1'b1;

    // Clean pass 0,1,2,3,0 with immediate grants
    do_step(0, 0, 0, 0, t0);
    for (int s = 0; s < 4; s++) begin
      do_step(0, 0, 0, 0, t1);
      chk("interval_gap", t1 - t0, IV + 3);
      t0 = t1;
    end
    @(negedge i_clk);
    chk("pass_done_cnt", pass_seen, exp_wraps);

    // Single-bit error at addr 1, write grant held off 5 cycles
    mem_d[1] = 32'he0813002 ^ 32'h8;
    mem_e[1] = ref_gen(32'he0813002);
    do_step(0, 0, 5, 0, t0);
    chk("fixed_word", mem_d[1], 32'he0813002);

    // Double-bit error at addr 2
    mem_d[2] = 32'he0813002 ^ 32'h18;
    mem_e[2] = ref_gen(32'he0813002);
    do_step(0, 1, 0, 0, t0);
    do_step(0, 0, 0, 0, t0);
    do_step(0, 0, 0, 0, t0);

    // Collision at addr 1 one cycle after read grant
    set_word(1, $urandom, 1);
    do_step(1, 0, 0, 0, t0);
    do_step(0, 0, 0, 0, t0);

    // Enable low holds IDLE
    i_enable = 1'b0;
    seen = 0;
    repeat (3 * IV + 4) begin @(negedge i_clk); if (o_mem_req === 1'b1) seen = 1; end
    chk("en_low_hold", seen, 0);
    i_enable = 1'b1;

    // Randomized scrub steps
    for (int s = 0; s < 60; s++) begin
      set_word(exp_ptr, $urandom, $urandom_range(0, 2));
      do_step($urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 3), 0, t0);
    end
    @(negedge i_clk);
    chk("pass_done_cnt2", pass_seen, exp_wraps);

    // Saturation, then clear coincident with an increment
    while (exp_corr < int'(SAT)) begin
      set_word(exp_ptr, $urandom, 1);
      do_step(0, 0, 0, 0, t0);
    end
    set_word(exp_ptr, $urandom, 1);
    do_step(0, 0, 0, 0, t0);
    chk("corr_saturated", o_corr_cnt, SAT);
    set_word(exp_ptr, $urandom, 1);
    do_step(0, 0, 0, 1, t0);

    // Reset in RD_WAIT abandons the step
    set_word(exp_ptr, $urandom, 1);
    wait_req();
    i_mem_gnt = 1'b1;
    @(negedge i_clk);
    i_mem_gnt = 1'b0;
    i_mem_rdata = mem_d[exp_ptr];
    i_mem_recc  = mem_e[exp_ptr];
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_req", o_mem_req, 1'b0);
    chk("mid_rst_addr", o_mem_addr, 0);
    chk("mid_rst_err_valid", o_err_valid, 1'b0);
    chk("mid_rst_err_addr", o_err_addr, 0);
    chk("mid_rst_err_uncorr", o_err_uncorr, 1'b0);
    chk("mid_rst_corr_cnt", o_corr_cnt, 0);
    chk("mid_rst_uncorr_cnt", o_uncorr_cnt, 0);
    chk("mid_rst_wdata", o_mem_wdata, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_ptr = 0; exp_corr = 0; exp_uncorr = 0;
    set_word(0, $urandom, 0);
    do_step(0, 0, 0, 0, t0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
